// File: rtl/dmem_responder_rv32i_pkg.sv
// Shared definitions for the RV32I data-memory responder.
//   - store type codes, as the core drives them from funct3[1:0]
//   - responder FSM state encoding
//   - wait-state counter width
package dmem_pkg_rv32i;

    localparam logic [1:0] STORE_B = 2'b00;
    localparam logic [1:0] STORE_H = 2'b01;
    localparam logic [1:0] STORE_W = 2'b10;
    localparam logic [1:0] STORE_X = 2'b11;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_responder_rv32i_if.sv
// Load/store bus between the core's memory stage (master) and the data-memory
// responder (slave).
//   req_*  : request channel, valid/ready handshake, master -> slave
//   resp_* : response channel, valid/ready handshake, slave -> master
interface dmem_responder_rv32i_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_store;
    logic [1:0]  req_storetype;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_store, req_storetype, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_store, req_storetype, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder_rv32i_lane_gen.sv
// Byte-lane generator for stores.
//   addr_lo    : byte offset within the word (addr[1:0])
//   storetype  : B/H/W/X access size
//   wdata      : LSB-justified store data
//   be         : per-byte write enable
//   wdata_lane : store data replicated into its target lanes
//   misaligned : half on an odd address or word on a non-zero offset
module dmem_lane_gen_rv32i
    import dmem_pkg_rv32i::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  storetype,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        misaligned = 1'b0;
        case (storetype)
            STORE_B: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            STORE_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            STORE_W: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                // Illegal size: no lanes; the top flags it as an error on stores.
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder_rv32i.sv
// Data-memory responder: target end of the RV32I core's load/store interface.
// One request at a time; WAIT_CYCLES wait states between acceptance and commit,
// then a response held until the requester takes it.
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : request/response channels (slave modport)
// Storage is never cleared by reset.
module dmem_responder_rv32i
    import dmem_pkg_rv32i::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                  clock,
    input logic                  reset,
    dmem_responder_rv32i_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              store_q, store_d;
    logic [1:0]        stype_q, stype_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic              misaligned;
    logic              out_of_range;
    logic              illegal;
    logic              err;
    logic              commit;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;

    dmem_lane_gen_rv32i u_lane_gen (
        .addr_lo    (addr_q[1:0]),
        .storetype  (stype_q),
        .wdata      (wdata_q),
        .be         (be),
        .wdata_lane (wdata_lane),
        .misaligned (misaligned)
    );

    assign idx          = addr_q[IDX_W+1:2];
    assign rd_word      = mem[idx];
    assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign illegal      = store_q && (stype_q == STORE_X);
    assign err          = illegal || misaligned || out_of_range;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        stype_d      = stype_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        commit       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    store_d = bus.req_store;
                    stype_d = bus.req_storetype;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                // Zero count means this edge is the commit edge.
                if (cnt_q == '0) begin
                    commit       = 1'b1;
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err;
                    resp_rdata_d = (err || store_q) ? 32'h0
                                                    : (rd_word >> {addr_q[1:0], 3'b000});
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            store_q      <= 1'b0;
            stype_q      <= STORE_B;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            store_q      <= store_d;
            stype_q      <= stype_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Reset gates the write so an access pending in WAIT is dropped.
    always_ff @(posedge clock) begin
        if (reset && commit && store_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder_rv32i.sv
// Directed bench: three responders (WAIT_CYCLES 2, 0, 3) share the stimulus;
// `sel` routes req_valid/resp_ready to one of them and muxes its outputs back.
module tb_dmem_responder_rv32i;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        valid, rready, store;
    logic [1:0]  stype;
    logic [31:0] addr, wdata;
    int          errors = 0;
    int          checks = 0;
    int          wc [3] = '{2, 0, 3};

    always #5 clk = ~clk;

    dmem_responder_rv32i_if if0 ();
    dmem_responder_rv32i_if if1 ();
    dmem_responder_rv32i_if if2 ();

    assign if0.req_valid = valid && (sel == 0);
    assign if1.req_valid = valid && (sel == 1);
    assign if2.req_valid = valid && (sel == 2);
    assign if0.resp_ready = rready && (sel == 0);
    assign if1.resp_ready = rready && (sel == 1);
    assign if2.resp_ready = rready && (sel == 2);
    assign if0.req_addr = addr;  assign if1.req_addr = addr;  assign if2.req_addr = addr;
    assign if0.req_wdata = wdata; assign if1.req_wdata = wdata; assign if2.req_wdata = wdata;
    assign if0.req_store = store; assign if1.req_store = store; assign if2.req_store = store;
    assign if0.req_storetype = stype;
    assign if1.req_storetype = stype;
    assign if2.req_storetype = stype;

    dmem_responder_rv32i #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clock(clk), .reset(rst_n), .bus(if0.slave));
    dmem_responder_rv32i #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clock(clk), .reset(rst_n), .bus(if1.slave));
    dmem_responder_rv32i #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut2 (
        .clock(clk), .reset(rst_n), .bus(if2.slave));

    logic        o_req_ready, o_resp_valid, o_err;
    logic [31:0] o_rdata;
    always_comb begin
        o_req_ready  = if0.req_ready;
        o_resp_valid = if0.resp_valid;
        o_rdata      = if0.resp_rdata;
        o_err        = if0.resp_err;
        if (sel == 1) begin
            o_req_ready  = if1.req_ready;
            o_resp_valid = if1.resp_valid;
            o_rdata      = if1.resp_rdata;
            o_err        = if1.resp_err;
        end else if (sel == 2) begin
            o_req_ready  = if2.req_ready;
            o_resp_valid = if2.resp_valid;
            o_rdata      = if2.resp_rdata;
            o_err        = if2.resp_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, check it is accepted and measure latency to resp_valid.
    task automatic send(input logic st, input logic [1:0] ty, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        int n;
        addr = a; wdata = d; store = st; stype = ty; valid = 1'b1;
        chk({tag, "/req_ready"}, 32'(o_req_ready), 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        while (!o_resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/latency"}, 32'(n), 32'(wc[sel] + 1));
    endtask

    task automatic finish_resp(input string tag);
        chk({tag, "/ready_in_resp"}, 32'(o_req_ready), 32'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk({tag, "/valid_clr"}, 32'(o_resp_valid), 32'd0);
        chk({tag, "/ready_back"}, 32'(o_req_ready), 32'd1);
        chk({tag, "/rdata_clr"}, o_rdata, 32'h0);
    endtask

    task automatic txn(input logic st, input logic [1:0] ty, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        send(st, ty, a, d, tag);
        chk({tag, "/rdata"}, o_rdata, exp_rd);
        chk({tag, "/err"}, 32'(o_err), 32'(exp_err));
        finish_resp(tag);
    endtask

    initial begin
        sel = 0; valid = 0; rready = 0; store = 0; stype = 2'b10; addr = 0; wdata = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst/resp_valid", 32'(o_resp_valid), 32'd0);
        chk("rst/rdata", o_rdata, 32'h0);
        chk("rst/err", 32'(o_err), 32'd0);
        chk("rst/req_ready", 32'(o_req_ready), 32'd1);

        // WAIT_CYCLES = 2
        txn(1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st_w");
        txn(0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w");
        txn(1, 2'b10, 32'h10, 32'h0, 32'h0, 0, "clr_w");
        txn(1, 2'b00, 32'h11, 32'h000000A5, 32'h0, 0, "st_b");
        txn(0, 2'b10, 32'h10, 32'h0, 32'h0000A500, 0, "ld_after_b");
        txn(0, 2'b00, 32'h13, 32'h0, 32'h0, 0, "ld_b13");
        txn(0, 2'b00, 32'h11, 32'h0, 32'h000000A5, 0, "ld_b11");
        txn(0, 2'b01, 32'h12, 32'h0, 32'h0, 0, "ld_h12");
        txn(1, 2'b01, 32'h13, 32'h1234, 32'h0, 1, "st_h_mis");
        txn(0, 2'b10, 32'h10, 32'h0, 32'h0000A500, 0, "ld_after_mis");
        txn(0, 2'b10, 32'h400, 32'h0, 32'h0, 1, "ld_oor");
        txn(1, 2'b11, 32'h10, 32'hFFFFFFFF, 32'h0, 1, "st_x");
        txn(0, 2'b10, 32'h10, 32'h0, 32'h0000A500, 0, "ld_after_x");
        txn(0, 2'b01, 32'h11, 32'h0, 32'h0, 1, "ld_h_mis");
        txn(1, 2'b01, 32'h12, 32'h0000BEEF, 32'h0, 0, "st_h");
        txn(0, 2'b10, 32'h10, 32'h0, 32'hBEEFA500, 0, "ld_after_h");

        // Response backpressure: held 5 cycles while new requests are offered.
        send(0, 2'b10, 32'h10, 32'h0, "stall");
        for (int i = 0; i < 5; i++) begin
            valid = ((i % 2) == 0);
            addr  = 32'h20 + 32'(4 * i);
            store = 1'b1;
            @(posedge clk); #1;
            chk("stall/resp_valid", 32'(o_resp_valid), 32'd1);
            chk("stall/rdata", o_rdata, 32'hBEEFA500);
            chk("stall/req_ready", 32'(o_req_ready), 32'd0);
        end
        valid = 1'b0;
        finish_resp("stall");
        repeat (4) begin
            @(posedge clk); #1;
            chk("stall/no_phantom", 32'(o_resp_valid), 32'd0);
        end

        // WAIT_CYCLES = 0
        sel = 1;
        txn(1, 2'b10, 32'h20, 32'h0BADF00D, 32'h0, 0, "w0_st");
        txn(0, 2'b10, 32'h20, 32'h0, 32'h0BADF00D, 0, "w0_ld");

        // WAIT_CYCLES = 3, reset during WAIT drops the store
        sel = 2;
        txn(1, 2'b10, 32'h20, 32'h11223344, 32'h0, 0, "w3_init");
        addr = 32'h20; wdata = 32'hFFFFFFFF; store = 1'b1; stype = 2'b10; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("w3_rst/in_wait", 32'(o_req_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("w3_rst/resp_valid", 32'(o_resp_valid), 32'd0);
        chk("w3_rst/req_ready", 32'(o_req_ready), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("w3_rst/no_resp", 32'(o_resp_valid), 32'd0);
        end
        txn(0, 2'b10, 32'h20, 32'h0, 32'h11223344, 0, "w3_ld");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder_rv32i.md
Name: dmem_responder_rv32i

Overview:
- Data-memory responder: the target end of the RV32I core's load/store interface.
- Accepts one load or store request at a time through a valid/ready handshake.
- Inserts a configurable number of wait states, performs byte-lane-correct writes, flags misaligned or out-of-range accesses, and returns a response through a second valid/ready handshake.
- Sits between the core's memory-access stage (ALU address, rs2 store data, store type) and the load selector; it replaces the zero-wait data memory once the core moves to a stalling memory interface.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; valid word index is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between acceptance and commit; legal range 0..15.

Ports:
- clock  in  1  single system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified (the rs2 value).
- req_store  in  1  1 = store, 0 = load.
- req_storetype  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  loaded word shifted right by 8*addr[1:0]; 0 for stores and errors.
- resp_err  out  1  access rejected.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - WAIT: wait-state counter running.
  - RESP: resp_valid=1.
- Reset (reset==0 at an edge):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 from the following cycle.
  - Storage contents are NOT cleared and are undefined after power-up.
- Accept: req_valid & req_ready at an edge.
  - Latch addr, wdata, store and storetype.
  - Load counter with WAIT_CYCLES.
  - Go to WAIT, or straight to commit if WAIT_CYCLES=0.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0: commit at that edge, then go to RESP.
  - resp_valid is first high exactly WAIT_CYCLES+1 cycles after the accepting edge.
- Commit (single edge):
  - Error when any of the following hold:
    - storetype=11 on a store.
    - half with addr[0]=1.
    - word with addr[1:0]!=0.
    - addr[31:2] >= DEPTH_WORDS.
  - On error: no write, resp_err=1, resp_rdata=0.
  - Store writes:
    - byte: lane addr[1:0] <= wdata[7:0].
    - half: lanes {addr[1],1}:{addr[1],0} <= wdata[15:0].
    - word: all lanes <= wdata.
    - Other lanes are unchanged. resp_rdata=0, resp_err=0.
  - Loads ignore storetype: resp_rdata = mem[addr[31:2]] >> (8*addr[1:0]), resp_err=0. Alignment is still checked using storetype as the access size, which the core drives from funct3.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready at an edge.
  - Then state goes to IDLE and resp_valid, resp_rdata and resp_err are cleared.
  - req_ready returns the following cycle; there is no same-cycle overlap.
- req_ready=0 in WAIT and RESP. req_valid there is ignored, and the request inputs may change freely.
- Reset mid-operation: reset in WAIT drops the pending access with no write. Reset in RESP drops the response.
- resp_ready while in IDLE or WAIT has no effect.

Decomposition:
- Shared package dmem_pkg_rv32i holds:
  - STORE_B/STORE_H/STORE_W/STORE_X storetype codes.
  - The state encoding IDLE/WAIT/RESP.
  - Counter width 4.
- One combinational sub-module, dmem_lane_gen_rv32i: takes addr[1:0], storetype and wdata; produces a 4-bit byte enable, lane-aligned write data and a misaligned flag.

Test Plan:
- Reset, then store word 0xDEADBEEF @0x10 and load @0x10 (WAIT_CYCLES=2) -> resp_valid at accept+3 each time; load rdata=0xDEADBEEF, err=0.
- Store byte 0xA5 @0x11 over 0x00000000 @0x10, then load word @0x10 -> 0x0000A500; load byte @0x13 -> rdata[7:0]=0x00.
- Store half 0x1234 @0x13 -> err=1; following load @0x10 returns unchanged 0x0000A500.
- Load word @(DEPTH_WORDS*4) -> err=1, rdata=0; storetype=11 store -> err=1, memory unchanged.
- resp_ready held low 5 cycles -> resp_valid/rdata stable for all 5; req_valid pulses during that window are not accepted; req_ready rises one cycle after the handshake.
- WAIT_CYCLES=0 accepts with resp at accept+1. Reset asserted in the WAIT of a store of 0xFFFFFFFF @0x20 (WAIT_CYCLES=3) -> after reset, load @0x20 returns its prior value.
